// File: rtl/nc_op_scheduler_if.sv
// Operand request / result response bundle for nc_op_scheduler.
// Requester i drives lane i of req_a/req_b; the scheduler drives the rsp_* side.
interface nc_op_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_a;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_b;
  logic                           rsp_valid;
  logic                           rsp_ready;
  logic [ID_W-1:0]                rsp_id;
  logic [DATA_W-1:0]              rsp_and;
  logic                           rsp_par;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_and, rsp_par
  );
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_and, rsp_par
  );
endinterface

// File: rtl/nc_op_scheduler.sv
// Round-robin scheduler sharing one AND/parity unit between NUM_REQ requesters.
// Optional NC_SCHED_STATS_EN adds a 16-bit response-handshake counter (op_count).
module nc_op_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  nc_op_scheduler_if.slave  bus,
`ifdef NC_SCHED_STATS_EN
  output logic [15:0]       op_count,
`endif
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   gid_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic              rsp_valid_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [DATA_W-1:0] rsp_and_q;
  logic              rsp_par_q;
  logic              gnt_found;
  logic [ID_W-1:0]   gnt_idx;
  logic              grant;
  logic              rsp_hs;
  int                idx;

  // First valid requester at or after ptr, wrapping at NUM_REQ-1.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_found && bus.req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(idx);
      end
    end
  end

  assign grant  = (state_q == IDLE) && gnt_found;
  assign rsp_hs = rsp_valid_q && bus.rsp_ready;
  assign ptr_d  = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_found) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // No grant is offered while reset is held, even though IDLE is forced.
  always_comb begin
    bus.req_ready = '0;
    if (grant && rst_n) bus.req_ready[gnt_idx] = 1'b1;
    busy = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      gid_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_and_q   <= '0;
      rsp_par_q   <= 1'b0;
    end else begin
      if (grant) begin
        ptr_q <= ptr_d;
        gid_q <= gnt_idx;
        a_q   <= bus.req_a[gnt_idx];
        b_q   <= bus.req_b[gnt_idx];
      end
      if (state_q == EXEC) begin
        rsp_and_q   <= a_q & b_q;
        rsp_par_q   <= ^{a_q, b_q};
        rsp_id_q    <= gid_q;
        rsp_valid_q <= 1'b1;
      end else if (rsp_hs) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_and   = rsp_and_q;
  assign bus.rsp_par   = rsp_par_q;

`ifdef NC_SCHED_STATS_EN
  logic [15:0] op_count_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      op_count_q <= '0;
    else if (rsp_hs) op_count_q <= op_count_q + 16'd1;
  end
  assign op_count = op_count_q;
`endif
endmodule
